// File: rtl/fft_frame_reorder.sv
// rtl/fft_frame_reorder.sv - ping-pong frame buffer that re-emits FFT frames in natural order
// with optional FFT-shift and a block exponent/error carried per frame.
module fft_frame_reorder #(
   parameter int LOG2_N    = 6,
   parameter int DATA_W    = 12,
   parameter int EXP_W     = 6,
   parameter int BITREV_IN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_fftshift,
   input  logic              sink_valid,
   output logic              sink_ready,
   input  logic [1:0]        sink_error,
   input  logic              sink_sop,
   input  logic              sink_eop,
   input  logic [DATA_W-1:0] sink_real,
   input  logic [DATA_W-1:0] sink_imag,
   input  logic [EXP_W-1:0]  sink_exp,
   output logic              source_valid,
   input  logic              source_ready,
   output logic [1:0]        source_error,
   output logic              source_sop,
   output logic              source_eop,
   output logic [DATA_W-1:0] source_real,
   output logic [DATA_W-1:0] source_imag,
   output logic [EXP_W-1:0]  source_exp
);

   localparam int N = 1 << LOG2_N;
   localparam int W = 2 * DATA_W;
   localparam logic [LOG2_N-1:0] LAST = LOG2_N'(N - 1);
   localparam logic [LOG2_N-1:0] HALF = LOG2_N'(N / 2);

   typedef enum logic {W_IDLE, W_FILL} w_state_t;
   typedef enum logic {R_IDLE, R_STREAM} r_state_t;

   logic [W-1:0]      mem [2*N];
   logic [W-1:0]      rd_q;

   logic              ready_en;
   logic [1:0]        full, full_nxt;
   logic [EXP_W-1:0]  bank_exp [2];
   logic [1:0]        bank_err [2];
   logic [1:0]        bank_shift;

   w_state_t          w_state, w_next;
   logic              wr_bank, wr_en, wr_last, accept;
   logic [LOG2_N-1:0] wr_k, wr_idx, wr_addr;
   logic [1:0]        err_acc, err_new;

   r_state_t          r_state, r_next;
   logic              iss_bank, issue_req, issue, rd_free;
   logic [LOG2_N-1:0] rd_j;
   logic [LOG2_N:0]   rd_addr;
   logic              p1_vld, p1_sop, p1_eop, p1_free, out_load;
   logic [1:0]        p1_err;
   logic [EXP_W-1:0]  p1_exp;

   assign sink_ready = ready_en & ~full[wr_bank];
   assign accept     = sink_valid & sink_ready;

   always_comb begin
      w_next = w_state;
      wr_en  = 1'b0;
      wr_idx = wr_k;
      if (accept) begin
         if (sink_sop) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            w_next = W_FILL;
         end else if (w_state == W_FILL) begin
            wr_en = 1'b1;
            if (wr_k == LAST) w_next = W_IDLE;
         end
      end
      wr_last = wr_en && (wr_idx == LAST);
      // bit 0 flags an eop that is missing on the last beat or present on any earlier one
      err_new = (sink_sop ? 2'b00 : err_acc) | sink_error
              | {1'b0, (wr_idx == LAST) ? ~sink_eop : sink_eop};
      wr_addr = wr_idx;
      if (BITREV_IN != 0)
         for (int b = 0; b < LOG2_N; b++) wr_addr[b] = wr_idx[LOG2_N-1-b];
   end

   always_comb begin
      full_nxt = full;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
      if (rd_free) full_nxt[iss_bank] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_en   <= 1'b0;
         w_state    <= W_IDLE;
         wr_bank    <= 1'b0;
         wr_k       <= '0;
         err_acc    <= '0;
         full       <= '0;
         bank_shift <= '0;
         for (int b = 0; b < 2; b++) begin
            bank_exp[b] <= '0;
            bank_err[b] <= '0;
         end
      end else begin
         ready_en <= 1'b1;
         w_state  <= w_next;
         full     <= full_nxt;
         if (wr_en) begin
            wr_k    <= wr_idx + 1'b1;
            err_acc <= err_new;
            if (sink_sop) begin
               bank_exp[wr_bank]   <= sink_exp;
               bank_shift[wr_bank] <= cfg_fftshift;
            end
            if (wr_last) begin
               bank_err[wr_bank] <= err_new;
               wr_bank           <= ~wr_bank;
            end
         end
      end
   end

   // Bank is released once its last word has left the RAM, so the writer can refill it
   // while that word is still in the output pipeline.
   assign out_load = p1_vld & (~source_valid | source_ready);
   assign p1_free  = ~p1_vld | out_load;

   always_comb begin
      r_next    = r_state;
      issue_req = 1'b0;
      case (r_state)
         R_IDLE:
            if (full[iss_bank]) begin
               issue_req = 1'b1;
               r_next    = R_STREAM;
            end
         R_STREAM: issue_req = 1'b1;
         default:  r_next = R_IDLE;
      endcase
      issue   = issue_req & p1_free;
      rd_free = issue & (rd_j == LAST);
      if (rd_free && !full[~iss_bank]) r_next = R_IDLE;
      rd_addr = {iss_bank, rd_j ^ (bank_shift[iss_bank] ? HALF : '0)};
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank, wr_addr}] <= {sink_real, sink_imag};
      if (issue) rd_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= R_IDLE;
         iss_bank     <= 1'b0;
         rd_j         <= '0;
         p1_vld       <= 1'b0;
         p1_sop       <= 1'b0;
         p1_eop       <= 1'b0;
         p1_exp       <= '0;
         p1_err       <= '0;
         source_valid <= 1'b0;
         source_sop   <= 1'b0;
         source_eop   <= 1'b0;
         source_exp   <= '0;
         source_error <= '0;
         source_real  <= '0;
         source_imag  <= '0;
      end else begin
         r_state <= r_next;
         if (issue) begin
            rd_j   <= rd_j + 1'b1;
            p1_sop <= (rd_j == '0);
            p1_eop <= (rd_j == LAST);
            p1_exp <= bank_exp[iss_bank];
            p1_err <= bank_err[iss_bank];
            if (rd_j == LAST) iss_bank <= ~iss_bank;
         end
         if (issue)         p1_vld <= 1'b1;
         else if (out_load) p1_vld <= 1'b0;
         if (out_load) begin
            source_valid               <= 1'b1;
            source_sop                 <= p1_sop;
            source_eop                 <= p1_eop;
            source_exp                 <= p1_exp;
            source_error               <= p1_err;
            {source_real, source_imag} <= rd_q;
         end else if (source_ready) begin
            source_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_reorder.sv
// tb/tb_fft_frame_reorder.sv - scoreboard bench for fft_frame_reorder: frame-level reference
// model, randomized data and backpressure, framing errors and mid-frame reset.
module tb_fft_frame_reorder;
   localparam int LOG2_N = 6;
   localparam int N      = 1 << LOG2_N;
   localparam int DATA_W = 12;
   localparam int EXP_W  = 6;

   logic              clk = 1'b0, reset = 1'b1, cfg_fftshift = 1'b0;
   logic              sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0, source_ready = 1'b1;
   logic [1:0]        sink_error = '0;
   logic [DATA_W-1:0] sink_real = '0, sink_imag = '0;
   logic [EXP_W-1:0]  sink_exp = '0;
   logic              sink_ready, source_valid, source_sop, source_eop;
   logic [1:0]        source_error;
   logic [DATA_W-1:0] source_real, source_imag;
   logic [EXP_W-1:0]  source_exp;

   fft_frame_reorder #(.LOG2_N(LOG2_N), .DATA_W(DATA_W), .EXP_W(EXP_W), .BITREV_IN(1)) dut (
      .clk(clk), .reset(reset), .cfg_fftshift(cfg_fftshift),
      .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
      .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
      .sink_exp(sink_exp), .source_valid(source_valid), .source_ready(source_ready),
      .source_error(source_error), .source_sop(source_sop), .source_eop(source_eop),
      .source_real(source_real), .source_imag(source_imag), .source_exp(source_exp));

   always #5 clk = ~clk;

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [1:0]        err;
      logic [EXP_W-1:0]  ex;
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } beat_t;

   beat_t exp_q[$];
   int    out_cyc[$];
   int    n_cmp = 0, n_bad = 0, cyc = 0;
   int    stall_cnt = 0, eop_cyc = 0, valid_cyc = 0, eop_out_cnt = 0;
   bit    lat_armed = 0, bp_on = 0;

   // frame-level reference state
   bit                m_in = 0;
   int                m_k = 0;
   logic [1:0]        m_err;
   logic [EXP_W-1:0]  m_exp;
   logic              m_sh;
   logic [DATA_W-1:0] m_re [N];
   logic [DATA_W-1:0] m_im [N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic int bitrev(input int x);
      int r;
      r = 0;
      for (int b = 0; b < LOG2_N; b++) r = r * 2 + ((x >> b) & 1);
      return r;
   endfunction

   task automatic model_accept(input logic sop, input logic eop, input logic [1:0] err,
                               input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                               input logic [EXP_W-1:0] ex, input logic sh);
      logic [DATA_W-1:0] nat_re [N];
      logic [DATA_W-1:0] nat_im [N];
      beat_t b;
      int src;
      if (sop) begin
         m_in = 1; m_k = 0; m_exp = ex; m_sh = sh; m_err = 2'b00;
      end
      if (!m_in) return;
      if ((m_k == N - 1) != eop) m_err = m_err | 2'b01;
      m_err = m_err | err;
      m_re[m_k] = re;
      m_im[m_k] = im;
      if (m_k == N - 1) begin
         for (int k = 0; k < N; k++) begin
            nat_re[bitrev(k)] = m_re[k];
            nat_im[bitrev(k)] = m_im[k];
         end
         for (int j = 0; j < N; j++) begin
            src   = m_sh ? (j + N / 2) % N : j;
            b.sop = (j == 0);
            b.eop = (j == N - 1);
            b.err = m_err;
            b.ex  = m_exp;
            b.re  = nat_re[src];
            b.im  = nat_im[src];
            exp_q.push_back(b);
         end
         m_in = 0;
      end else begin
         m_k++;
      end
   endtask

   task automatic send_beat(input logic sop, input logic eop, input logic [1:0] err,
                            input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                            input logic [EXP_W-1:0] ex, input logic sh);
      int t;
      sink_valid   = 1'b1;
      sink_sop     = sop;
      sink_eop     = eop;
      sink_error   = err;
      sink_real    = re;
      sink_imag    = im;
      sink_exp     = sop ? ex : EXP_W'($urandom);
      cfg_fftshift = sop ? sh : 1'($urandom);
      t = 0;
      @(negedge clk);
      while (!sink_ready && t < 3000) begin
         stall_cnt++;
         t++;
         @(negedge clk);
      end
      if (!sink_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sink_timeout: actual sink_ready 0 required 1 within 3000 cycles");
      end else begin
         model_accept(sop, eop, err, re, im, ex, sh);
         if (eop) eop_cyc = cyc;
      end
      @(posedge clk);
      #1;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
   endtask

   // mode 0: bit-reversed ramp; 1: random back-to-back; 2: random with idle gaps
   task automatic send_frame(input int mode, input logic [EXP_W-1:0] ex, input logic sh);
      logic [DATA_W-1:0] re, im;
      logic [1:0] err;
      for (int k = 0; k < N; k++) begin
         if (mode == 0) begin
            re  = DATA_W'(bitrev(k));
            im  = DATA_W'(N - 1 - bitrev(k));
            err = 2'b00;
         end else begin
            re  = DATA_W'($urandom);
            im  = DATA_W'($urandom);
            err = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            if (mode == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         send_beat(k == 0, k == N - 1, err, re, im, ex, sh);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      beat_t got, e;
      if (!reset && source_valid) begin
         if (lat_armed) begin
            valid_cyc = cyc;
            lat_armed = 0;
         end
         if (source_ready) begin
            got = {source_sop, source_eop, source_error, source_exp, source_real, source_imag};
            out_cyc.push_back(cyc);
            if (source_eop) eop_out_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: actual %h required no beat", got);
            end else begin
               e = exp_q.pop_front();
               check("out_beat", 64'(got), 64'(e));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual simulation still running required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_eop, base, eop0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sink_ready", 64'(sink_ready), 64'd0);
      check("rst_source_valid", 64'(source_valid), 64'd0);
      check("rst_source_fields", 64'({source_sop, source_eop, source_error, source_exp,
                                      source_real, source_imag}), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("sink_ready_after_release", 64'(sink_ready), 64'd1);
      @(posedge clk); #1;

      // ramp in natural order (exp 5), then FFT-shifted (exp 3)
      lat_armed = 1;
      send_frame(0, EXP_W'(5), 1'b0);
      first_eop = eop_cyc;
      send_frame(0, EXP_W'(3), 1'b1);
      drain();
      check("first_valid_latency", 64'(valid_cyc - first_eop), 64'd3);

      // four frames back-to-back
      stall_cnt = 0;
      base = out_cyc.size();
      repeat (4) send_frame(1, EXP_W'($urandom), 1'($urandom));
      drain();
      check("b2b_sink_stalls", 64'(stall_cnt), 64'd0);
      if (out_cyc.size() >= base + 4 * N)
         check("b2b_contiguous", 64'(out_cyc[base + 4*N - 1] - out_cyc[base]), 64'(4 * N - 1));
      else
         check("b2b_beat_count", 64'(out_cyc.size() - base), 64'(4 * N));

      // downstream stalled: two frames fill both banks, third must wait
      source_ready = 1'b0;
      stall_cnt = 0;
      send_frame(1, EXP_W'($urandom), 1'($urandom));
      send_frame(1, EXP_W'($urandom), 1'($urandom));
      check("bp_fill_no_stall", 64'(stall_cnt), 64'd0);
      stall_cnt = 0;
      fork
         send_frame(1, EXP_W'($urandom), 1'($urandom));
         begin
            repeat (150) @(posedge clk);
            #1 source_ready = 1'b1;
         end
      join
      check("bp_sink_ready_fell", 64'(stall_cnt > 100), 64'd1);
      drain();

      // stray beats, sop restart at k=20 with missing eop, early eop at k=10
      for (int k = 0; k < 3; k++) send_beat(1'b0, 1'b0, 2'b00, DATA_W'($urandom), DATA_W'($urandom), EXP_W'(1), 1'b0);
      for (int k = 0; k < 20; k++) send_beat(k == 0, 1'b0, 2'b00, DATA_W'($urandom), DATA_W'($urandom), EXP_W'(2), 1'b1);
      for (int k = 0; k < N; k++) send_beat(k == 0, 1'b0, 2'b00, DATA_W'(k), DATA_W'(3 * k), EXP_W'(4), 1'b0);
      for (int k = 0; k < N; k++) send_beat(k == 0, (k == 10) || (k == N - 1), 2'b00, DATA_W'($urandom), DATA_W'($urandom), EXP_W'(6), 1'b1);
      drain();

      // random gaps with random downstream backpressure
      bp_on = 1;
      fork
         while (bp_on) begin
            @(posedge clk);
            #1 source_ready = 1'($urandom_range(0, 1));
         end
         begin
            repeat (6) send_frame(2, EXP_W'($urandom), 1'($urandom));
            drain();
            bp_on = 0;
         end
      join
      source_ready = 1'b1;
      drain();

      // reset with one frame stalled at the output and another 30 beats in
      source_ready = 1'b0;
      send_frame(1, EXP_W'(7), 1'b0);
      for (int k = 0; k < 30; k++) send_beat(k == 0, 1'b0, 2'b00, DATA_W'($urandom), DATA_W'($urandom), EXP_W'(8), 1'b0);
      @(negedge clk);
      check("pre_reset_valid", 64'(source_valid), 64'd1);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("midrst_source_valid", 64'(source_valid), 64'd0);
      check("midrst_source_fields", 64'({source_sop, source_eop, source_error, source_exp,
                                         source_real, source_imag}), 64'd0);
      check("midrst_sink_ready", 64'(sink_ready), 64'd0);
      exp_q.delete();
      m_in = 0;
      eop0 = eop_out_cnt;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      source_ready = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("no_eop_after_reset", 64'(eop_out_cnt - eop0), 64'd0);
      check("idle_after_reset", 64'(source_valid), 64'd0);
      @(posedge clk); #1;
      send_frame(0, EXP_W'(9), 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
